snake_dir_input: RTL and testbench
==================================

# snake_dir_input

Direction-input stage feeding `snake_controller`. It takes the four raw direction push-buttons and produces the registered `mov_dir`. Each button is synchronised and debounced. The most recent legal request is latched as pending and committed only on the rising edge of the 1 Hz movement clock. 180° reversals are rejected, and direction is frozen while the game is dead.

## Interface
- `DEBOUNCE_CYCLES`, default 252000 (10 ms at 25.2 MHz): consecutive stable cycles required before a debounced level changes.
- `CNT_W`, default `$clog2(DEBOUNCE_CYCLES+1)`: debounce counter width.

Ports:
- `clk_25_2`  in  1  sole clock; every flop is in this domain.
- `rst`  in  1  synchronous, active-high reset.
- `btn`  in  4  raw asynchronous buttons, active-high. Bit 0 = right, 1 = down, 2 = left, 3 = up; bit index equals the `mov_dir` code.
- `clk_1`  in  1  movement clock, treated as an asynchronous level.
- `game_state`  in  2  from `snake_controller`.
- `mov_dir`  out  2  committed direction (00 right, 01 down, 10 left, 11 up).
- `dir_pending`  out  1  a legal request is waiting for commit.
- `btn_db`  out  4  debounced button levels, for debug LEDs.

## Operation
- **Synchroniser:** each `btn` bit passes through 2 flops. `clk_1` passes through 3 flops (s1, s2, s3). `move_edge` = s2 & ~s3.
- **Debounce, per button:** a counter clears whenever the synchronised level equals `btn_db[i]`, otherwise it increments. When it reaches `DEBOUNCE_CYCLES - 1` while still mismatched, `btn_db[i]` toggles and the counter clears. The counter saturates and never wraps.
- **Press event:** `press[i]` = `btn_db[i]` & ~`btn_db_d[i]`, a one-cycle pulse. If several pulse in the same cycle, the lowest index wins.
- **Legality:** a request `r` is legal iff `r != mov_dir` and `r != (mov_dir ^ 2'b10)`. Illegal requests are dropped silently.
- **Pending register:** a legal request overwrites `pend_dir` and sets `dir_pending`; the latest press wins.
- **Commit:** on `move_edge`, if `dir_pending` is set, `mov_dir` <= `pend_dir` and `dir_pending` clears.
- **Press in the same cycle as `move_edge`:** the commit happens first. The press is checked against the newly committed value and, if legal, becomes the new pending.
- **Dead state:** while `game_state == GAME_STATE_DEAD`:
  - commits are suppressed;
  - `dir_pending` is forced to 0 and presses are ignored;
  - `mov_dir` holds.
  
  Normal behaviour resumes on the first cycle `game_state` is not dead.
- **Reset values:** `mov_dir` = 00 (right, matching the player start), `dir_pending` = 0, `pend_dir` = 00, `btn_db` = 0, all counters and synchroniser flops 0.
- **Reset mid-operation:** all of the above are re-initialised on the next clock. Any partially debounced press is discarded.

## Timing
- **Button to pending:** `btn` rises before clock edge 0. The synchronised level is valid after edge 2, `btn_db` flips at edge 2 + `DEBOUNCE_CYCLES`, and `dir_pending` / `pend_dir` update at edge 3 + `DEBOUNCE_CYCLES`.
- **Commit:** `clk_1` rises before edge 0; `mov_dir` changes at edge 3.
  - This is ~120 ns after the `clk_1` edge, so `mov_dir` is stable for a full second before the next `clk_1` posedge samples it in `snake_controller`.
  - Requirement: `mov_dir` never changes except within 3 cycles after a `clk_1` rising edge.
- **Glitch rejection:** a bounce shorter than `DEBOUNCE_CYCLES` produces no `btn_db` change and no press.
- **Release:** no press event and no effect on pending.

## Structure
- Shared package `snake_pkg`:
  - `DIR_RIGHT` / `DIR_DOWN` / `DIR_LEFT` / `DIR_UP` constants and a `dir_t` 2-bit typedef;
  - `GAME_STATE_*` and `ENTITY_*` constants, migrated from `config.h` so both blocks share one definition.
- Sub-module `btn_debounce` (parameters `DEBOUNCE_CYCLES`, `CNT_W`; ports `clk_25_2`, `rst`, `din`, `dout`), containing the 2-flop synchroniser and counter, instantiated 4×.
- Top level holds the `clk_1` synchroniser, the press priority, the legality check, the pending register and the commit.

## Test plan
All scenarios run with `DEBOUNCE_CYCLES` = 4.
1. **Reset:** `rst` high for 2 cycles → `mov_dir` = 00, `dir_pending` = 0, `btn_db` = 0.
2. **Legal press then commit:** clean press of `btn[1]` → `dir_pending` = 1 at edge 7, `mov_dir` still 00. Then `clk_1` rises → `mov_dir` = 01 three cycles later and `dir_pending` = 0.
3. **Reversal rejected:** with `mov_dir` = 00, press `btn[2]` → `dir_pending` stays 0. After a `clk_1` edge, `mov_dir` stays 00.
4. **Bounce and multi-press:**
   - 3-cycle glitch on `btn[3]` → no press.
   - `btn[1]` and `btn[3]` pressed in the same cycle while `mov_dir` = 00 → `pend_dir` = 01.
   - Later `btn[3]` alone → `pend_dir` = 11; commit → `mov_dir` = 11.
5. **Press coincident with commit:** `pend_dir` = 01 pending and `mov_dir` = 00; a `btn[3]` press event lands on the `move_edge` cycle → `mov_dir` = 01, `dir_pending` = 0 (11 is a reversal of 01). Repeat with `btn[2]` → `dir_pending` = 1, `pend_dir` = 10.
6. **Dead freeze:** `game_state` = `GAME_STATE_DEAD`, press `btn[1]` and apply 3 `clk_1` edges → `mov_dir` holds, `dir_pending` = 0. Return to alive → next legal press and commit behave normally.

Source files
------------

// File: rtl/snake_pkg.sv
// Definitions shared by snake_dir_input and snake_controller: directions, game
// states, board entities and the reversal check.
package snake_pkg;

    localparam int unsigned DIR_W   = 2;
    localparam int unsigned STATE_W = 2;
    localparam int unsigned ENTITY_W = 2;

    typedef logic [DIR_W-1:0] dir_t;

    localparam dir_t DIR_RIGHT = 2'd0;
    localparam dir_t DIR_DOWN  = 2'd1;
    localparam dir_t DIR_LEFT  = 2'd2;
    localparam dir_t DIR_UP    = 2'd3;

    localparam logic [STATE_W-1:0] GAME_STATE_START = 2'd0;
    localparam logic [STATE_W-1:0] GAME_STATE_PLAY  = 2'd1;
    localparam logic [STATE_W-1:0] GAME_STATE_DEAD  = 2'd2;
    localparam logic [STATE_W-1:0] GAME_STATE_WIN   = 2'd3;

    localparam logic [ENTITY_W-1:0] ENTITY_EMPTY = 2'd0;
    localparam logic [ENTITY_W-1:0] ENTITY_SNAKE = 2'd1;
    localparam logic [ENTITY_W-1:0] ENTITY_FOOD  = 2'd2;
    localparam logic [ENTITY_W-1:0] ENTITY_WALL  = 2'd3;

    // Opposite directions differ only in bit 1, so a reversal is cur ^ 2'b10.
    function automatic logic dir_legal(input dir_t req, input dir_t cur);
        return (req != cur) && (req != (cur ^ 2'b10));
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser plus saturating stability counter for one raw button.
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 252000,
    parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic clk_25_2,
    input  logic rst,
    input  logic din,
    output logic dout
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             db_q;
    logic             db_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // The >= compare also keeps the counter from ever wrapping.
    always_comb begin
        db_d  = db_q;
        cnt_d = cnt_q;
        if (sync2_q == db_q) begin
            cnt_d = '0;
        end else if (cnt_q >= CNT_LAST) begin
            db_d  = ~db_q;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_25_2) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            db_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= din;
            sync2_q <= sync1_q;
            db_q    <= db_d;
            cnt_q   <= cnt_d;
        end
    end

    assign dout = db_q;

endmodule

// File: rtl/snake_dir_input.sv
// Direction-input stage: debounced buttons become a pending direction that is
// committed to mov_dir on each rising edge of the 1 Hz movement clock.
module snake_dir_input
    import snake_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 252000,
    parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic               clk_25_2,
    input  logic               rst,
    input  logic [3:0]         btn,
    input  logic               clk_1,
    input  logic [STATE_W-1:0] game_state,
    output logic [DIR_W-1:0]   mov_dir,
    output logic               dir_pending,
    output logic [3:0]         btn_db
);

    logic       clk1_s1_q;
    logic       clk1_s2_q;
    logic       clk1_s3_q;
    logic [3:0] btn_db_d_q;
    dir_t       mov_dir_q;
    dir_t       mov_dir_d;
    dir_t       pend_dir_q;
    dir_t       pend_dir_d;
    logic       dir_pending_q;
    logic       dir_pending_d;

    logic       move_edge_c;
    logic       dead_c;
    logic [3:0] press_c;
    logic       press_any_c;
    dir_t       req_c;

    for (genvar i = 0; i < 4; i++) begin : g_db
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_db (
            .clk_25_2(clk_25_2),
            .rst     (rst),
            .din     (btn[i]),
            .dout    (btn_db[i])
        );
    end

    assign move_edge_c = clk1_s2_q & ~clk1_s3_q;
    assign dead_c      = (game_state == GAME_STATE_DEAD);
    assign press_c     = btn_db & ~btn_db_d_q;

    // Lowest pressed index wins when several presses land together.
    always_comb begin
        req_c       = DIR_RIGHT;
        press_any_c = 1'b0;
        for (int i = 3; i >= 0; i--) begin
            if (press_c[i]) begin
                req_c       = dir_t'(DIR_W'(i));
                press_any_c = 1'b1;
            end
        end
    end

    // Commit first, then judge a same-cycle press against the new direction.
    always_comb begin
        mov_dir_d     = mov_dir_q;
        pend_dir_d    = pend_dir_q;
        dir_pending_d = dir_pending_q;
        if (dead_c) begin
            dir_pending_d = 1'b0;
        end else begin
            if (move_edge_c && dir_pending_q) begin
                mov_dir_d     = pend_dir_q;
                dir_pending_d = 1'b0;
            end
            if (press_any_c && dir_legal(req_c, mov_dir_d)) begin
                pend_dir_d    = req_c;
                dir_pending_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_25_2) begin
        if (rst) begin
            clk1_s1_q     <= 1'b0;
            clk1_s2_q     <= 1'b0;
            clk1_s3_q     <= 1'b0;
            btn_db_d_q    <= '0;
            mov_dir_q     <= DIR_RIGHT;
            pend_dir_q    <= DIR_RIGHT;
            dir_pending_q <= 1'b0;
        end else begin
            clk1_s1_q     <= clk_1;
            clk1_s2_q     <= clk1_s1_q;
            clk1_s3_q     <= clk1_s2_q;
            btn_db_d_q    <= btn_db;
            mov_dir_q     <= mov_dir_d;
            pend_dir_q    <= pend_dir_d;
            dir_pending_q <= dir_pending_d;
        end
    end

    assign mov_dir     = mov_dir_q;
    assign dir_pending = dir_pending_q;

endmodule

// File: tb/tb_snake_dir_input.sv
// Bench for snake_dir_input with DEBOUNCE_CYCLES = 4: expected observations are
// queued with their due cycle when stimulus is applied and checked as they fall due.
module tb_snake_dir_input;
    import snake_pkg::*;

    localparam int unsigned DB_CYC = 4;
    localparam int F_MOV  = 0;
    localparam int F_PEND = 1;
    localparam int F_DB   = 2;

    logic       clk_25_2 = 1'b0;
    logic       rst;
    logic [3:0] btn;
    logic       clk_1;
    logic [1:0] game_state;
    logic [1:0] mov_dir;
    logic       dir_pending;
    logic [3:0] btn_db;

    typedef struct {
        string tag;
        int    fld;
        int    at;
        int    val;
    } exp_t;

    exp_t       sb_q[$];
    int         cyc       = 0;
    int         last_rise = -100;
    int         n_checks  = 0;
    int         n_errors  = 0;
    logic [1:0] prev_mov  = 2'bxx;

    snake_dir_input #(.DEBOUNCE_CYCLES(DB_CYC)) dut (
        .clk_25_2   (clk_25_2),
        .rst        (rst),
        .btn        (btn),
        .clk_1      (clk_1),
        .game_state (game_state),
        .mov_dir    (mov_dir),
        .dir_pending(dir_pending),
        .btn_db     (btn_db)
    );

    always #20 clk_25_2 = ~clk_25_2;
    always @(posedge clk_25_2) cyc++;

    task automatic chk(input string tag, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s @cyc %0d: got %0d expected %0d", tag, cyc, act, exp);
        end
    endtask

    function automatic int obs(input int f);
        case (f)
            F_MOV:   return int'(mov_dir);
            F_PEND:  return int'(dir_pending);
            default: return int'(btn_db);
        endcase
    endfunction

    // Queue an expectation dc cycles after the most recent edge.
    task automatic exp_at(input string tag, input int f, input int dc, input int v);
        exp_t e;
        e.tag = tag;
        e.fld = f;
        e.at  = cyc + dc;
        e.val = v;
        sb_q.push_back(e);
    endtask

    always @(negedge clk_25_2) begin
        for (int i = sb_q.size() - 1; i >= 0; i--) begin
            if (sb_q[i].at == cyc) begin
                chk(sb_q[i].tag, obs(sb_q[i].fld), sb_q[i].val);
                sb_q.delete(i);
            end
        end
        // mov_dir may only move within 3 cycles of a clk_1 rise.
        if (!$isunknown(prev_mov) && mov_dir !== prev_mov)
            chk("mov_window", int'((cyc > last_rise) && (cyc - last_rise <= 3)), 1);
        prev_mov = mov_dir;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk_25_2);
            #1;
        end
    endtask

    task automatic tap(input logic [3:0] m);
        btn = m;
        step(10);
        btn = 4'b0000;
        step(10);
    endtask

    task automatic commit_pulse();
        clk_1     = 1'b1;
        last_rise = cyc;
        step(6);
        clk_1 = 1'b0;
        step(6);
    endtask

    task automatic commit_expect(input string tag, input int mv);
        exp_at(tag, F_MOV, 3, mv);
        exp_at({tag, "_pend"}, F_PEND, 3, 0);
        commit_pulse();
    endtask

    // Press then commit; pending must rise at edge 7 after the press.
    task automatic move_to(input string tag, input logic [3:0] m, input int mv);
        exp_at({tag, "_pend"}, F_PEND, 7, 1);
        tap(m);
        commit_expect(tag, mv);
    endtask

    task automatic coincident(input string tag, input logic [3:0] m,
                              input int mv, input int pend);
        exp_at({tag, "_mov_before"}, F_MOV, 6, int'(DIR_RIGHT));
        exp_at({tag, "_mov"}, F_MOV, 7, mv);
        exp_at({tag, "_pend"}, F_PEND, 7, pend);
        exp_at({tag, "_pend_hold"}, F_PEND, 9, pend);
        btn = m;
        step(4);
        clk_1     = 1'b1;
        last_rise = cyc;
        step(6);
        btn   = 4'b0000;
        clk_1 = 1'b0;
        step(12);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst        = 1'b1;
        btn        = 4'b0000;
        clk_1      = 1'b0;
        game_state = GAME_STATE_PLAY;
        exp_at("rst_mov", F_MOV, 2, 0);
        exp_at("rst_pend", F_PEND, 2, 0);
        exp_at("rst_db", F_DB, 2, 0);
        step(2);
        rst = 1'b0;
        step(3);

        // Reversal and same-direction requests are dropped.
        exp_at("rev_db_early", F_DB, 5, 0);
        exp_at("rev_db", F_DB, 6, 4'b0100);
        exp_at("rev_pend", F_PEND, 8, 0);
        tap(4'b0100);
        exp_at("same_pend", F_PEND, 8, 0);
        tap(4'b0001);
        exp_at("rev_mov", F_MOV, 3, 0);
        exp_at("rev_mov_late", F_MOV, 5, 0);
        commit_pulse();

        // A 3-cycle bounce never reaches btn_db.
        btn = 4'b1000;
        exp_at("glitch_db6", F_DB, 6, 0);
        exp_at("glitch_db7", F_DB, 7, 0);
        exp_at("glitch_pend", F_PEND, 9, 0);
        step(3);
        btn = 4'b0000;
        step(12);

        // Simultaneous down+up: down wins; release leaves pending alone.
        exp_at("multi_db", F_DB, 6, 4'b1010);
        exp_at("multi_pend_early", F_PEND, 6, 0);
        exp_at("multi_pend", F_PEND, 7, 1);
        exp_at("multi_mov", F_MOV, 7, 0);
        exp_at("release_db", F_DB, 16, 0);
        exp_at("release_pend", F_PEND, 19, 1);
        tap(4'b1010);
        exp_at("commit_mov_early", F_MOV, 2, 0);
        exp_at("commit_pend_early", F_PEND, 2, 1);
        commit_expect("multi_commit", int'(DIR_DOWN));

        move_to("back_right", 4'b0001, int'(DIR_RIGHT));

        // Latest legal press overwrites the pending one.
        exp_at("latest_pend1", F_PEND, 7, 1);
        tap(4'b0010);
        exp_at("latest_pend2", F_PEND, 7, 1);
        tap(4'b1000);
        commit_expect("latest_commit", int'(DIR_UP));

        exp_at("rev_up_pend", F_PEND, 8, 0);
        tap(4'b0010);
        move_to("up_to_right", 4'b0001, int'(DIR_RIGHT));

        // Press landing on the move_edge cycle is judged against the new direction.
        exp_at("co1_setup", F_PEND, 7, 1);
        tap(4'b0010);
        coincident("co_rev", 4'b1000, int'(DIR_DOWN), 0);
        move_to("co_back", 4'b0001, int'(DIR_RIGHT));
        exp_at("co2_setup", F_PEND, 7, 1);
        tap(4'b0010);
        coincident("co_left", 4'b0100, int'(DIR_DOWN), 1);
        commit_expect("co_left_commit", int'(DIR_LEFT));

        // Dead: pending cleared, presses and commits ignored.
        exp_at("pre_dead_pend", F_PEND, 7, 1);
        tap(4'b1000);
        game_state = GAME_STATE_DEAD;
        exp_at("dead_clear", F_PEND, 1, 0);
        step(2);
        exp_at("dead_press7", F_PEND, 7, 0);
        exp_at("dead_press8", F_PEND, 8, 0);
        tap(4'b0010);
        for (int k = 0; k < 3; k++) begin
            exp_at("dead_mov", F_MOV, 3, int'(DIR_LEFT));
            commit_pulse();
        end
        game_state = GAME_STATE_PLAY;
        step(1);
        commit_expect("alive_stale", int'(DIR_LEFT));
        move_to("alive_move", 4'b0010, int'(DIR_DOWN));

        step(5);
        chk("sb_drain", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
